pulse_tick_counter: RTL and testbench



---
 rtl/pulse_tick_counter.sv | 123 ++++++++++++
 tb/tb_pulse_tick_counter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_tick_counter.sv
// Measures how long start stays high in prescaled ticks, then classifies it.
// Optional TICK_SYNC_EN adds a 2-flop synchronizer on start.
module pulse_tick_counter #(
    parameter int DIV         = 25000,
    parameter int CNT_W       = 15,
    parameter int LONG_THRESH = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [CNT_W-1:0] tick_total,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             is_long,
    output logic             saturated
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(LONG_THRESH);

    logic start_s;

`ifdef TICK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], start};
        end
    end

    assign start_s = sync_q[1];
`else
    assign start_s = start;
`endif

    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             long_q, long_d;
    logic             sat_q, sat_d;
    logic             start_d_q;

    logic rise, fall, count;

    assign rise  = start_s & ~start_d_q;
    assign fall  = ~start_s & start_d_q & busy_q;
    assign count = start_s & start_d_q & busy_q;

    always_comb begin
        presc_d = '0;
        total_d = total_q;
        tick_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        long_d  = long_q;
        sat_d   = sat_q;
        unique case (1'b1)
            rise: begin
                total_d = '0;
                sat_d   = 1'b0;
                busy_d  = 1'b1;
            end
            fall: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                long_d = (total_q >= THRESH);
            end
            count: begin
                if (presc_q == PRE_LAST) begin
                    tick_d = 1'b1;
                    // counter pins at max; saturation is sticky until next rise
                    if (total_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        total_d = total_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            total_q   <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            long_q    <= 1'b0;
            sat_q     <= 1'b0;
            start_d_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            total_q   <= total_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            long_q    <= long_d;
            sat_q     <= sat_d;
            start_d_q <= start_s;
        end
    end

    assign tick_total = total_q;
    assign tick       = tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign is_long    = long_q;
    assign saturated  = sat_q;

endmodule

// File: tb/tb_pulse_tick_counter.sv
// Bench for pulse_tick_counter: vector table, corner sequences and random
// start patterns checked every cycle against an elapsed-time reference model.
module tb_pulse_tick_counter;

`ifdef TICK_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start_a;
    logic        start_b;

    logic [14:0] tt_a, tt_c;
    logic [3:0]  tt_b;
    logic        tk_a, bz_a, dn_a, lg_a, st_a;
    logic        tk_c, bz_c, dn_c, lg_c, st_c;
    logic        tk_b, bz_b, dn_b, lg_b, st_b;

    pulse_tick_counter #(.DIV(4), .CNT_W(15), .LONG_THRESH(5)) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .tick_total(tt_a), .tick(tk_a), .busy(bz_a),
        .done(dn_a), .is_long(lg_a), .saturated(st_a)
    );

    pulse_tick_counter #(.DIV(4), .CNT_W(15), .LONG_THRESH(6)) u_c (
        .clk(clk), .reset(reset), .start(start_a),
        .tick_total(tt_c), .tick(tk_c), .busy(bz_c),
        .done(dn_c), .is_long(lg_c), .saturated(st_c)
    );

    pulse_tick_counter #(.DIV(2), .CNT_W(4), .LONG_THRESH(6)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .tick_total(tt_b), .tick(tk_b), .busy(bz_b),
        .done(dn_b), .is_long(lg_b), .saturated(st_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Reference: a pulse is described by edges elapsed since its rise.
    typedef struct {
        bit busy;
        bit prev;
        bit tick;
        bit done;
        bit lng;
        bit sat;
        int elapsed;
        int total;
    } m_t;

    function automatic m_t step(m_t m, bit s, int div, int maxv, int th);
        m_t n;
        n      = m;
        n.tick = 1'b0;
        n.done = 1'b0;
        if (s && !m.prev) begin
            n.busy    = 1'b1;
            n.elapsed = 0;
            n.total   = 0;
            n.sat     = 1'b0;
        end else if (!s && m.prev && m.busy) begin
            n.busy = 1'b0;
            n.done = 1'b1;
            n.lng  = (m.total >= th);
        end else if (s && m.busy) begin
            n.elapsed = m.elapsed + 1;
            n.tick    = (n.elapsed % div) == 0;
            n.sat     = (n.elapsed / div) > maxv;
            n.total   = n.sat ? maxv : n.elapsed / div;
        end
        n.prev = s;
        return n;
    endfunction

    m_t   ma, mc, mb;
    logic [1:0] sha, shb;
    logic ea, eb;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma  = '{default: 0};
            mc  = '{default: 0};
            mb  = '{default: 0};
            sha = 2'b00;
            shb = 2'b00;
        end else begin
            ea  = (SYNC != 0) ? sha[1] : start_a;
            eb  = (SYNC != 0) ? shb[1] : start_b;
            sha = {sha[0], start_a};
            shb = {shb[0], start_b};
            ma  = step(ma, ea, 4, 32767, 5);
            mc  = step(mc, ea, 4, 32767, 6);
            mb  = step(mb, eb, 2, 15, 6);
        end
    end

    int errors;
    int checks;
    int tick_cnt_a;
    int tick_cnt_b;
    int done_cnt_a;
    int done_cnt_b;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string nm, m_t m, int tt, bit tk, bit bz,
                       bit dn, bit lg, bit st);
        chk({nm, ".tick_total"}, tt, m.total);
        chk({nm, ".tick"}, int'(tk), int'(m.tick));
        chk({nm, ".busy"}, int'(bz), int'(m.busy));
        chk({nm, ".done"}, int'(dn), int'(m.done));
        chk({nm, ".is_long"}, int'(lg), int'(m.lng));
        chk({nm, ".saturated"}, int'(st), int'(m.sat));
        chk({nm, ".done_tick_excl"}, int'(dn & tk), 0);
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp("a", ma, int'(tt_a), tk_a, bz_a, dn_a, lg_a, st_a);
        cmp("c", mc, int'(tt_c), tk_c, bz_c, dn_c, lg_c, st_c);
        cmp("b", mb, int'(tt_b), tk_b, bz_b, dn_b, lg_b, st_b);
        if (tk_a) tick_cnt_a++;
        if (tk_b) tick_cnt_b++;
        if (dn_a) done_cnt_a++;
        if (dn_b) done_cnt_b++;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_done_a(string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = dn_a;
        end
        chk({nm, ".done_seen"}, int'(seen), 1);
    endtask

    task automatic wait_done_b(string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = dn_b;
        end
        chk({nm, ".done_seen"}, int'(seen), 1);
    endtask

    typedef struct {
        int hi;
        int lo;
        int exp_total;
        bit exp_long5;
        bit exp_long6;
    } vec_t;

    vec_t vecs[6];

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        // start = number of edges start is sampled high; ticks = (hi-1)/4
        vecs[0] = '{hi: 21, lo: 6, exp_total: 5, exp_long5: 1, exp_long6: 0};
        vecs[1] = '{hi: 3,  lo: 6, exp_total: 0, exp_long5: 0, exp_long6: 0};
        vecs[2] = '{hi: 25, lo: 6, exp_total: 6, exp_long5: 1, exp_long6: 1};
        vecs[3] = '{hi: 9,  lo: 6, exp_total: 2, exp_long5: 0, exp_long6: 0};
        vecs[4] = '{hi: 4,  lo: 6, exp_total: 0, exp_long5: 0, exp_long6: 0};
        vecs[5] = '{hi: 5,  lo: 6, exp_total: 1, exp_long5: 0, exp_long6: 0};

        // Reset held with start high: nothing may move.
        @(negedge clk);
        start_a    = 1'b1;
        start_b    = 1'b1;
        tick_cnt_a = 0;
        tick_cnt_b = 0;
        cycles(5);
        chk("rst.tick_total", int'(tt_a), 0);
        chk("rst.busy", int'(bz_a), 0);
        chk("rst.ticks_a", tick_cnt_a, 0);
        chk("rst.ticks_b", tick_cnt_b, 0);

        // start already high on the first post-reset edge counts as a rise.
        reset = 1'b1;
        cycles(1 + SYNC);
        chk("rel.busy_a", int'(bz_a), 1);
        chk("rel.busy_b", int'(bz_b), 1);
        start_a = 1'b0;
        start_b = 1'b0;
        cycles(8);

        for (int i = 0; i < 6; i++) begin
            tick_cnt_a = 0;
            done_cnt_a = 0;
            start_a    = 1'b1;
            cycles(vecs[i].hi);
            start_a = 1'b0;
            wait_done_a($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.total", i), int'(tt_a), vecs[i].exp_total);
            chk($sformatf("vec%0d.ticks", i), tick_cnt_a, vecs[i].exp_total);
            chk($sformatf("vec%0d.long5", i), int'(lg_a), int'(vecs[i].exp_long5));
            chk($sformatf("vec%0d.long6", i), int'(lg_c), int'(vecs[i].exp_long6));
            cycles(vecs[i].lo);
            chk($sformatf("vec%0d.hold", i), int'(tt_a), vecs[i].exp_total);
            chk($sformatf("vec%0d.dones", i), done_cnt_a, 1);
        end

        // Saturation on the 4-bit counter.
        tick_cnt_b = 0;
        start_b    = 1'b1;
        cycles(40);
        start_b = 1'b0;
        wait_done_b("sat");
        chk("sat.total", int'(tt_b), 15);
        chk("sat.flag", int'(st_b), 1);
        chk("sat.ticks", tick_cnt_b, 19);
        cycles(4);

        // Back-to-back: 12 ticks, one low cycle, 3 ticks.
        done_cnt_a = 0;
        start_a    = 1'b1;
        cycles(49);
        start_a = 1'b0;
        cycles(1);
        start_a = 1'b1;
        cycles(13);
        start_a = 1'b0;
        wait_done_a("b2b");
        cycles(2);
        chk("b2b.dones", done_cnt_a, 2);
        chk("b2b.total", int'(tt_a), 3);
        chk("b2b.sat", int'(st_a), 0);

        // Reset mid-measurement clears everything without a done.
        start_a = 1'b1;
        cycles(14);
        done_cnt_a = 0;
        reset      = 1'b0;
        cycles(2);
        chk("midrst.total", int'(tt_a), 0);
        chk("midrst.busy", int'(bz_a), 0);
        start_a = 1'b0;
        reset   = 1'b1;
        cycles(6);
        chk("midrst.dones", done_cnt_a, 0);

        // Random start patterns, checked every cycle by the model.
        for (int i = 0; i < 60; i++) begin
            start_a = $urandom_range(1, 0) == 1;
            start_b = $urandom_range(1, 0) == 1;
            cycles($urandom_range(20, 1));
        end
        start_a = 1'b0;
        start_b = 1'b0;
        cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
